// File: rtl/opll_bus_writer.sv
// Host-side write initiator for the YM2413-style register bus: buffers (reg, value)
// requests in a small FIFO and replays each one as an address cycle then a data cycle.
module opll_bus_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int ADDR_WAIT  = 12,
  parameter int DATA_WAIT  = 84
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic [7:0]                    i_req_reg,
  input  logic [7:0]                    i_req_data,
  output logic [7:0]                    o_D,
  output logic                          o_A0,
  output logic                          o_CS,
  output logic                          o_WR,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_WW  = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int MAX_CYC = (MAX_SS > MAX_WW) ? MAX_SS : MAX_WW;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [AW:0]   FULL_LVL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] AWAIT_LD  = CW'(ADDR_WAIT - 1);
  localparam logic [CW-1:0] DWAIT_LD  = CW'(DATA_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_A_SETUP, S_A_STROBE, S_A_WAIT, S_D_SETUP, S_D_STROBE, S_D_WAIT
  } state_t;

  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_level;
  logic          r_ready;
  logic          r_avail;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_D, r_data;
  logic          r_A0, r_CS, r_WR, r_busy;

  logic          w_push, w_pop, w_cntZero, w_goIdle, w_busyNext;
  logic [AW:0]   w_levelNext;
  logic [15:0]   w_head;

  assign w_push    = i_req_valid && r_ready;
  assign w_cntZero = (r_cnt == '0);
  assign w_head    = r_mem[r_rptr];
  // r_avail lags the level by one cycle, giving the head entry a cycle to settle before launch
  assign w_pop     = r_avail && ((r_state == S_IDLE) || ((r_state == S_D_WAIT) && w_cntZero));
  assign w_goIdle  = (r_state == S_D_WAIT) && w_cntZero && !r_avail;

  always_comb begin
    w_levelNext = r_level;
    if (w_push && !w_pop)
      w_levelNext = r_level + LVL_ONE;
    else if (!w_push && w_pop)
      w_levelNext = r_level - LVL_ONE;
  end

  assign w_busyNext = (w_levelNext != '0) || w_pop || ((r_state != S_IDLE) && !w_goIdle);

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= {i_req_reg, i_req_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ready <= 1'b1;
      r_avail <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      r_level <= w_levelNext;
      r_ready <= (w_levelNext != FULL_LVL);
      r_avail <= (r_level != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_D     <= '0;
      r_data  <= '0;
      r_A0    <= 1'b0;
      r_CS    <= 1'b0;
      r_WR    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_busy <= w_busyNext;
      if (w_pop) begin
        r_state <= S_A_SETUP;
        r_cnt   <= SETUP_LD;
        r_D     <= w_head[15:8];
        r_data  <= w_head[7:0];
        r_A0    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: ;
          S_A_SETUP, S_D_SETUP: begin
            if (w_cntZero) begin
              r_state <= (r_state == S_A_SETUP) ? S_A_STROBE : S_D_STROBE;
              r_cnt   <= STROBE_LD;
              r_CS    <= 1'b1;
              r_WR    <= 1'b1;
            end else r_cnt <= r_cnt - CNT_ONE;
          end
          S_A_STROBE, S_D_STROBE: begin
            if (w_cntZero) begin
              r_state <= (r_state == S_A_STROBE) ? S_A_WAIT : S_D_WAIT;
              r_cnt   <= (r_state == S_A_STROBE) ? AWAIT_LD : DWAIT_LD;
              r_CS    <= 1'b0;
              r_WR    <= 1'b0;
            end else r_cnt <= r_cnt - CNT_ONE;
          end
          S_A_WAIT: begin
            if (w_cntZero) begin
              r_state <= S_D_SETUP;
              r_cnt   <= SETUP_LD;
              r_D     <= r_data;
              r_A0    <= 1'b1;
            end else r_cnt <= r_cnt - CNT_ONE;
          end
          S_D_WAIT: begin
            if (w_cntZero) r_state <= S_IDLE;
            else r_cnt <= r_cnt - CNT_ONE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_req_ready = r_ready;
  assign o_level     = r_level;
  assign o_D         = r_D;
  assign o_A0        = r_A0;
  assign o_CS        = r_CS;
  assign o_WR        = r_WR;
  assign o_busy      = r_busy;

endmodule
